// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared constants, the id-width helper and the sequencer state type for the
// mult_share_arb block. Imported by rr_grant and mult_share_arb.
//
// Optional feature macro used by the block: MULT_ARB_STATS_EN (per-requester
// grant counters); nothing in this package depends on it.
package mult_arb_pkg;

    localparam int N_REQ = 4;
    localparam int W     = 4;
    localparam int CNT_W = 8;

    // An index into a single-entry set still needs one bit of storage.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = clog2_min1(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mult_share_arb_rr_grant.sv
// rr_grant
// Combinational round-robin grant: the first set bit of req at or after ptr,
// wrapping modulo N_REQ, wins.
//
// Ports:
//   req    : request vector
//   ptr    : search start index (always < N_REQ)
//   gnt    : one-hot grant, zero when no request
//   gnt_id : index of the granted request (0 when none)
//   any    : at least one request present
module rr_grant
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = mult_arb_pkg::N_REQ,
    parameter int ID_W  = mult_arb_pkg::clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        any    = |req;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/multiplier_4bit.sv
// multiplier_4bit
// Shared signed 4x4 combinational multiplier; the full 8-bit product is
// returned, so no overflow is possible.
//
// Ports:
//   a_i, b_i : signed 4-bit operands
//   p_o      : signed 8-bit product
module multiplier_4bit (
    input  logic signed [3:0] a_i,
    input  logic signed [3:0] b_i,
    output logic signed [7:0] p_o
);

    // Both operands are signed, so they sign-extend to the 8-bit context.
    assign p_o = a_i * b_i;

endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb
// Round-robin arbiter/sequencer sharing one signed multiplier_4bit between
// N_REQ valid/ready requesters. At most one request is accepted per cycle;
// its product is registered and returned on a single response channel tagged
// with the requester index. Accept and consume may coincide (no bubble).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed signed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_prod    : owner index and signed 2W-bit product
//   busy                : rsp_valid | any req_valid
//   grant_cnt           : saturating per-requester accept counters, packed
//                         CNT_W bits per requester; only with MULT_ARB_STATS_EN
//
// State   | meaning
// --------+------------------------------------------------
// EMPTY   | no product held, rsp_valid low
// FULL    | response registers hold an unconsumed product
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = mult_arb_pkg::N_REQ,
    parameter int W     = mult_arb_pkg::W,
    parameter int CNT_W = mult_arb_pkg::CNT_W,
    localparam int ID_W = mult_arb_pkg::clog2_min1(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2*W-1:0]     rsp_prod,
    input  logic               rsp_ready,
    output logic               busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [2*W-1:0]  rsp_prod_q, rsp_prod_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic             slot_free;
    logic             accept;

    logic signed [W-1:0]   a_sel;
    logic signed [W-1:0]   b_sel;
    logic signed [2*W-1:0] prod;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    assign a_sel = req_a[int'(gnt_id)*W +: W];
    assign b_sel = req_b[int'(gnt_id)*W +: W];

    multiplier_4bit u_mult (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (prod)
    );

    assign rsp_valid = (state_q == FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    // Gating on rst keeps a request from seeing a handshake that the
    // register update is about to discard.
    assign req_ready = (rst || !slot_free) ? '0 : gnt;
    assign accept    = gnt_any && slot_free && !rst;
    assign busy      = rsp_valid || (|req_valid);
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_prod_d = rsp_prod_q;
        if (accept) begin
            state_d    = FULL;
            rsp_id_d   = gnt_id;
            rsp_prod_d = prod;
            ptr_d      = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_prod_q <= rsp_prod_d;
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
// Scoreboarded bench for mult_share_arb: a round-robin reference model
// predicts req_ready each cycle and queues the expected {id, product} on each
// accept; entries are popped and compared when the response is consumed.
module tb_mult_share_arb;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_prod;
    logic           rsp_ready;
    logic           busy;
`ifdef MULT_ARB_STATS_EN
    logic [N*CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mult_share_arb #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] prod;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic m_vld    = 1'b0;
    int   m_ptr    = 0;

    // One clock cycle: drive at negedge, check before the posedge, advance model.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic rr, output int g);
        logic [N-1:0] exp_rdy;
        exp_t         e;
        int           sa;
        int           sbv;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        g = -1;
        if (!m_vld || rr) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
        end
        checks++;
        if (rsp_valid !== m_vld) begin
            failures++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_vld);
        end
        checks++;
        if (busy !== (m_vld || (|v))) begin
            failures++;
            $display("FAIL busy: got %b expected %b", busy, (m_vld || (|v)));
        end
        if (m_vld && rr) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: response consumed with empty queue");
            end else begin
                e = sb.pop_front();
                checks++;
                if (rsp_id !== e.id || rsp_prod !== e.prod) begin
                    failures++;
                    $display("FAIL response: got id=%0d prod=%h expected id=%0d prod=%h",
                             rsp_id, rsp_prod, e.id, e.prod);
                end
            end
        end
        if (g >= 0) begin
            sa     = $signed(a[g*W +: W]);
            sbv    = $signed(b[g*W +: W]);
            e.id   = g[1:0];
            e.prod = 8'(sa * sbv);
            sb.push_back(e);
            m_ptr  = (g + 1) % N;
            m_vld  = 1'b1;
        end else if (rr) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = v;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL req_ready_in_reset: got %b expected 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_prod !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: got valid=%b id=%0d prod=%h expected 0 0 00",
                     rsp_valid, rsp_id, rsp_prod);
        end
        m_vld = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic drain();
        int g;
        for (int i = 0; i < 4 && m_vld; i++) cycle('0, '0, '0, 1'b1, g);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset(4'b1111);
    endtask

    task automatic test_single();
        int g;
        do_reset(4'b0000);
        cycle(4'b0001, 16'h000A, 16'h000F, 1'b1, g);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== 8'd6) begin
            failures++;
            $display("FAIL single: got valid=%b id=%0d prod=%h expected 1 0 06",
                     rsp_valid, rsp_id, rsp_prod);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int g;
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 16'hC723, 16'hD9E5, 1'b1, g);
            #1;
            checks++;
            if (rsp_id !== order[i]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got id=%0d expected %0d", i, rsp_id, order[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int g;
        do_reset(4'b0000);
        cycle(4'b0100, 16'h0B00, 16'h0E00, 1'b1, g);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 16'h1B21, 16'h3E31, 1'b0, g);
            #1;
            checks++;
            if (rsp_prod !== 8'd10 || rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b prod=%h expected 1 0a",
                         i, rsp_valid, rsp_prod);
            end
        end
        cycle(4'b1111, 16'h1B21, 16'h3E31, 1'b1, g);
        drain();
    endtask

    task automatic test_extremes();
        int g;
        cycle(4'b0010, 16'h0080, 16'h0080, 1'b1, g);
        #1;
        checks++;
        if (rsp_prod !== 8'h40) begin
            failures++;
            $display("FAIL ext_neg8_sq: got %h expected 40", rsp_prod);
        end
        cycle(4'b1000, 16'h8000, 16'h7000, 1'b1, g);
        #1;
        checks++;
        if (rsp_prod !== 8'hC8) begin
            failures++;
            $display("FAIL ext_neg8_x7: got %h expected c8", rsp_prod);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int g;
        cycle(4'b1000, 16'h3000, 16'h2000, 1'b0, g);
        cycle(4'b0100, 16'h0300, 16'h0200, 1'b0, g);
        do_reset(4'b0110);
        cycle(4'b0110, 16'h0350, 16'h0260, 1'b1, g);
        #1;
        checks++;
        if (rsp_id !== 2'd1 || rsp_prod !== 8'd30) begin
            failures++;
            $display("FAIL reset_mid_grant: got id=%0d prod=%h expected 1 1e", rsp_id, rsp_prod);
        end
        drain();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 120; i++) begin
            cycle(4'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0), g);
        end
        drain();
    endtask

`ifdef MULT_ARB_STATS_EN
    task automatic test_stats();
        int g;
        do_reset(4'b0000);
        for (int i = 0; i < 300; i++) cycle(4'b0010, 16'h0010, 16'h0010, 1'b1, g);
        drain();
        #1;
        checks++;
        if (grant_cnt !== 32'h0000_FF00) begin
            failures++;
            $display("FAIL stats: got %h expected 0000ff00", grant_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_reset_mid();
        test_random();
`ifdef MULT_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one signed 4-bit combinational multiplier (`multiplier_4bit`) between `N_REQ` requesters. Each requester uses a valid/ready request channel. The block accepts at most one request per cycle, captures its operands, and registers the signed product. It returns the product on a single response channel tagged with the requester index. It sits between the requesting datapaths and the shared multiplier, so the multiplier never sees contention.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `W`, default 4: operand width, two's complement. Fixed to 4 when the datapath is `multiplier_4bit`.
- `CNT_W`, default 8: width of each grant counter (used only with `MULT_ARB_STATS_EN`).
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `req_valid`, input, N_REQ: bit i means requester i has a request pending.
- `req_a`, input, N_REQ*W: signed operand a. Requester i occupies bits [i*W +: W].
- `req_b`, input, N_REQ*W: signed operand b, same packing as `req_a`.
- `req_ready`, output, N_REQ: one-hot or zero. Bit i high means request i is accepted this cycle.
- `rsp_valid`, output, 1: the response registers hold an unconsumed product.
- `rsp_id`, output, clog2(N_REQ): index of the requester that owns the product.
- `rsp_prod`, output, 2W: signed product a*b.
- `rsp_ready`, input, 1: the consumer accepts the response.
- `busy`, output, 1: equals `rsp_valid | (|req_valid)`.
- `grant_cnt`, output, N_REQ*CNT_W: per-requester accept counters. Present only with `MULT_ARB_STATS_EN`.

## Operation
- **FSM states.** The state register has two states, EMPTY and FULL. FULL is equivalent to `rsp_valid`.
- **Slot availability.** `slot_free = !rsp_valid | rsp_ready`.
- **Grant selection.** The grant is combinational round-robin over `req_valid`, starting the search at pointer `ptr`. The first valid index at or after `ptr`, wrapping modulo N_REQ, wins.
- **Accept condition.** `req_ready[g] = slot_free & req_valid[g]`. All other `req_ready` bits are 0. If no requester is valid, every `req_ready` bit is 0.
- **On accept (`req_ready[g]` high):**
  - The operands of requester g drive the multiplier.
  - `rsp_prod`, `rsp_id` and `rsp_valid` load on the same edge.
  - `ptr` becomes (g+1) mod N_REQ.
  - The state becomes FULL.
- **Response consumed with no new accept** (`rsp_valid & rsp_ready` and no accept): the state becomes EMPTY. `rsp_prod` and `rsp_id` keep their last values.
- **Response consumed and new request accepted in the same cycle:** the state stays FULL and the new product replaces the old one. No bubble is inserted.
- **Backpressure** (`rsp_valid & !rsp_ready`): all `req_ready` bits are 0, the response registers hold, and `ptr` holds.
- **Requester rules:**
  - `req_valid` and the operands must stay stable until `req_ready` is seen.
  - A requester may drop `req_valid` before it is accepted. The block tolerates this, and that requester is simply not granted.
- **Arithmetic:**
  - Full signed product, sign-extended into 2W bits, so no overflow is possible.
  - For W=4 the range is -56..64. For example, -8 * -8 = +64 and -8 * 7 = -56.
- **Reset values:**
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_prod` = 0.
  - `ptr` = 0, state EMPTY.
  - `grant_cnt` = 0.
  - `req_ready` = 0 while `rst` is high.
- **Reset during operation:** a pending response is discarded and not presented. A request that was being accepted in the reset cycle is not accepted.

## Timing
- **Latency:** a request accepted at edge k produces a response with `rsp_valid` high after edge k, that is, one cycle.
- **Throughput:** one product per cycle while `rsp_ready` is held high and requests are pending.
- **Fairness:** with all N_REQ requesters continuously valid, each one is granted exactly once every N_REQ accepts.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`. There is no path from `req_*` to any `rsp_*` output.

## Configuration
- **Macro:** `MULT_ARB_STATS_EN`.
- **Defined:**
  - The `grant_cnt` port exists.
  - Counter i increments on every accept of requester i.
  - Each counter saturates at 2^CNT_W-1.
  - Counters clear only on `rst`.
- **Undefined:** the `grant_cnt` port and its counters are absent. Arbitration behaviour is identical with or without the macro.

## Structure
- **Shared package `mult_arb_pkg`:**
  - Default constants `N_REQ`, `W` and `CNT_W`.
  - Derived `ID_W = clog2(N_REQ)`.
  - The state enum (EMPTY, FULL).
- **Sub-module `rr_grant`:**
  - Inputs: `req` (N_REQ bits) and `ptr`.
  - Outputs: one-hot `gnt`, `gnt_id`, and `any` (at least one request present).
  - Purely combinational.
- **Product datapath:** the existing `multiplier_4bit`, instantiated once and fed by a mux controlled by `gnt_id`.

## Test plan
- **Single requester, no backpressure.** After reset, only requester 0 is valid with a=4'b1010 (-6) and b=4'b1111 (-1). Expect `req_ready[0]` in that cycle, then the next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_prod`=+6.
- **Round-robin order.** All 4 requesters valid continuously, `rsp_ready`=1, with operands 3*5, 2*-2, 7*-7 and -4*-3. Expect grants in order 0,1,2,3,0 and products 15, -4, -49, 12 with matching `rsp_id` values.
- **Backpressure.** `rsp_ready`=0 for 3 cycles after a response with product 10 (from -5*-2). Expect all `req_ready` bits 0 and `rsp_prod` held at 10. Raise `rsp_ready`: the next request is accepted in that same cycle with no bubble.
- **Extremes.** -8*-8 gives +64 (8'h40). -8*7 gives -56 (8'hC8).
- **Reset during operation.** Assert `rst` while `rsp_valid`=1. Expect `rsp_valid`=0 and `ptr`=0 after the edge, and the next grant goes to the lowest valid index.
- **Statistics (only with `MULT_ARB_STATS_EN`).** Grant requester 1 300 times with CNT_W=8. Expect its `grant_cnt` to read 255 and the other counters to read 0.
